instruction_fetch_sequencer: RTL and testbench

Control-side stage that sits directly upstream of the ALU-system datapath and drives its memory, IR and ARF control inputs. Each 16-bit instruction is fetched as two byte reads at PC: low byte first, then high byte. PC is incremented after each byte. The captured IR word is decoded into fields and handed to the execute controller over a valid/ready handshake. The block also counts accepted instructions.

---
 rtl/instruction_fetch_sequencer.sv | 134 +++++++++++++
 tb/tb_instruction_fetch_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_sequencer.sv
// Two-byte instruction fetch sequencer driving memory, IR and ARF controls.
// Optional illegal-opcode trap enabled by defining ILLEGAL_OPCODE_EN.
module instruction_fetch_sequencer (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Fetch_En,
  input  logic        Exec_Ready,
  input  logic [15:0] IROut,
  output logic        Mem_CS,
  output logic        Mem_WR,
  output logic        IR_Write,
  output logic        IR_LH,
  output logic [1:0]  ARF_OutDSel,
  output logic [1:0]  ARF_FunSel,
  output logic [2:0]  ARF_RegSel,
  output logic        Instr_Valid,
  output logic [5:0]  Instr_Opcode,
  output logic [1:0]  Instr_Rsel,
  output logic [7:0]  Instr_Addr,
  output logic [15:0] Fetch_Count,
  output logic        Illegal
);

  localparam logic [1:0] PC_OUTSEL   = 2'b00;
  localparam logic [2:0] PC_REGSEL   = 3'b011;
  localparam logic [2:0] NONE_REGSEL = 3'b111;
  localparam logic [1:0] FUN_CLEAR   = 2'b00;
  localparam logic [1:0] FUN_INC     = 2'b01;

  localparam logic [2:0] ST_RST_PC   = 3'd0;
  localparam logic [2:0] ST_FETCH_LO = 3'd1;
  localparam logic [2:0] ST_FETCH_HI = 3'd2;
  localparam logic [2:0] ST_HOLD     = 3'd3;
`ifdef ILLEGAL_OPCODE_EN
  localparam logic [2:0] ST_TRAP     = 3'd4;
  localparam logic [5:0] MAX_OPCODE  = 6'd33;
`endif

  logic [2:0]  state_q, state_d;
  logic [15:0] fetch_count_q, fetch_count_d;
  logic        opcode_illegal_s;

`ifdef ILLEGAL_OPCODE_EN
  assign opcode_illegal_s = (IROut[15:10] > MAX_OPCODE);
`else
  assign opcode_illegal_s = 1'b0;
`endif

  // Next-state and accepted-instruction counter logic
  always_comb begin
    state_d       = state_q;
    fetch_count_d = fetch_count_q;
    case (state_q)
      ST_RST_PC: state_d = ST_FETCH_LO;
      ST_FETCH_LO: begin
        if (Fetch_En) state_d = ST_FETCH_HI;
        else          state_d = state_q;
      end
      ST_FETCH_HI: begin
        if (Fetch_En) state_d = ST_HOLD;
        else          state_d = state_q;
      end
      ST_HOLD: begin
`ifdef ILLEGAL_OPCODE_EN
        if (opcode_illegal_s) begin
          state_d = ST_TRAP;
        end else
`endif
        if (Exec_Ready) begin
          state_d       = ST_FETCH_LO;
          fetch_count_d = fetch_count_q + 16'd1;
        end else begin
          state_d = state_q;
        end
      end
`ifdef ILLEGAL_OPCODE_EN
      ST_TRAP: state_d = ST_TRAP;
`endif
      default: state_d = ST_RST_PC;
    endcase
  end

  // State and counter registers with synchronous reset
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q       <= ST_RST_PC;
      fetch_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // Control decode; fetch states fall back to defaults while Fetch_En is low
  always_comb begin
    Mem_CS      = 1'b1;
    Mem_WR      = 1'b0;
    IR_Write    = 1'b0;
    IR_LH       = 1'b0;
    ARF_OutDSel = PC_OUTSEL;
    ARF_FunSel  = FUN_INC;
    ARF_RegSel  = NONE_REGSEL;
    Instr_Valid = 1'b0;
    Illegal     = 1'b0;
    case (state_q)
      ST_RST_PC: begin
        ARF_RegSel = PC_REGSEL;
        ARF_FunSel = FUN_CLEAR;
      end
      ST_FETCH_LO, ST_FETCH_HI: begin
        if (Fetch_En) begin
          Mem_CS     = 1'b0;
          IR_Write   = 1'b1;
          IR_LH      = (state_q == ST_FETCH_HI);
          ARF_RegSel = PC_REGSEL;
          ARF_FunSel = FUN_INC;
        end else begin
          Mem_CS = 1'b1;
        end
      end
      ST_HOLD: Instr_Valid = !opcode_illegal_s;
`ifdef ILLEGAL_OPCODE_EN
      ST_TRAP: Illegal = 1'b1;
`endif
      default: Mem_CS = 1'b1;
    endcase
  end

  assign Instr_Opcode = IROut[15:10];
  assign Instr_Rsel   = IROut[9:8];
  assign Instr_Addr   = IROut[7:0];
  assign Fetch_Count  = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch_sequencer.sv
// Randomized self-checking bench for instruction_fetch_sequencer with a
// PC/IR/memory environment and a byte-counting reference model.
module tb_instruction_fetch_sequencer;

  logic        Clock = 1'b0;
  logic        Reset, Fetch_En, Exec_Ready;
  logic [15:0] IROut;
  logic        Mem_CS, Mem_WR, IR_Write, IR_LH;
  logic [1:0]  ARF_OutDSel, ARF_FunSel;
  logic [2:0]  ARF_RegSel;
  logic        Instr_Valid, Illegal;
  logic [5:0]  Instr_Opcode;
  logic [1:0]  Instr_Rsel;
  logic [7:0]  Instr_Addr;
  logic [15:0] Fetch_Count;

  int tests_run = 0;
  int tests_failed = 0;

  instruction_fetch_sequencer dut (
    .Clock(Clock), .Reset(Reset), .Fetch_En(Fetch_En), .Exec_Ready(Exec_Ready),
    .IROut(IROut), .Mem_CS(Mem_CS), .Mem_WR(Mem_WR), .IR_Write(IR_Write),
    .IR_LH(IR_LH), .ARF_OutDSel(ARF_OutDSel), .ARF_FunSel(ARF_FunSel),
    .ARF_RegSel(ARF_RegSel), .Instr_Valid(Instr_Valid), .Instr_Opcode(Instr_Opcode),
    .Instr_Rsel(Instr_Rsel), .Instr_Addr(Instr_Addr), .Fetch_Count(Fetch_Count),
    .Illegal(Illegal)
  );

  always #5 Clock = ~Clock;

  // Datapath stand-in: memory, PC register and IR register
  logic [7:0]  mem [256];
  logic [15:0] pc = 16'd0;
  logic [15:0] ir = 16'd0;
  assign IROut = ir;

  always @(posedge Clock) begin
    if (ARF_RegSel == 3'b011) begin
      if (ARF_FunSel == 2'b00)      pc <= 16'd0;
      else if (ARF_FunSel == 2'b01) pc <= pc + 16'd1;
    end
    if (IR_Write && !Mem_CS) begin
      if (IR_LH) ir[15:8] <= mem[pc[7:0]];
      else       ir[7:0]  <= mem[pc[7:0]];
    end
  end

  // Reference model: bytes fetched of the current instruction, instruction index
  bit          in_rst = 1'b1;
  bit          trapped = 1'b0;
  int          bytes = 0;
  int          instr_idx = 0;
  logic [15:0] exp_count = 16'd0;

  function automatic logic [7:0] lo_byte();
    return mem[(2 * instr_idx) % 256];
  endfunction

  function automatic logic [7:0] hi_byte();
    return mem[(2 * instr_idx + 1) % 256];
  endfunction

  function automatic bit is_illegal();
`ifdef ILLEGAL_OPCODE_EN
    logic [7:0] h;
    h = hi_byte();
    return (h[7:2] > 6'd33);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [60:0] observe();
    logic [15:0] f, a;
    f = Instr_Valid ? {Instr_Opcode, Instr_Rsel, Instr_Addr} : 16'd0;
    a = IR_Write ? pc : 16'd0;
    return {Mem_CS, Mem_WR, IR_Write, IR_LH, ARF_OutDSel, ARF_FunSel, ARF_RegSel,
            Instr_Valid, Illegal, Fetch_Count, f, a};
  endfunction

  function automatic logic [60:0] expect_vec();
    logic cs, irw, lh, v, il;
    logic [1:0] fs;
    logic [2:0] rs;
    logic [15:0] fld, pa;
    cs = 1'b1; irw = 1'b0; lh = 1'b0; v = 1'b0; il = 1'b0;
    fs = 2'b01; rs = 3'b111; fld = 16'd0; pa = 16'd0;
    if (trapped) begin
      il = 1'b1;
    end else if (in_rst) begin
      rs = 3'b011; fs = 2'b00;
    end else if (bytes < 2) begin
      if (Fetch_En) begin
        cs = 1'b0; irw = 1'b1; lh = (bytes == 1); rs = 3'b011; fs = 2'b01;
        pa = 16'(2 * instr_idx + bytes);
      end
    end else begin
      v = !is_illegal();
      fld = v ? {hi_byte(), lo_byte()} : 16'd0;
    end
    return {cs, 1'b0, irw, lh, 2'b00, fs, rs, v, il, exp_count, fld, pa};
  endfunction

  task automatic drive(input logic f, input logic e, input logic r);
    @(negedge Clock);
    Fetch_En = f; Exec_Ready = e; Reset = r;
    #1;
  endtask

  task automatic advance();
    @(posedge Clock);
    if (Reset) begin
      in_rst = 1'b1; trapped = 1'b0; bytes = 0; instr_idx = 0; exp_count = 16'd0;
    end else if (trapped) begin
      trapped = 1'b1;
    end else if (in_rst) begin
      in_rst = 1'b0;
    end else if (bytes < 2) begin
      if (Fetch_En) bytes = bytes + 1;
    end else if (is_illegal()) begin
      trapped = 1'b1;
    end else if (Exec_Ready) begin
      bytes = 0; instr_idx = instr_idx + 1; exp_count = exp_count + 16'd1;
    end
  endtask

  task automatic test_reset_fetch();
    mem[0] = 8'h12; mem[1] = 8'h34;
    drive(1'b0, 1'b0, 1'b1); advance();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, (i == 0));
      tests_run++;
      if (observe() !== expect_vec()) begin
        tests_failed++;
        $display("FAIL reset_hold cyc%0d got=%h want=%h", i, observe(), expect_vec());
      end
      advance();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      tests_run++;
      if (observe() !== expect_vec()) begin
        tests_failed++;
        $display("FAIL reset_fetch cyc%0d got=%h want=%h", i, observe(), expect_vec());
      end
      if (i < 2) advance();
    end
    tests_run++;
    if ({Instr_Valid, Instr_Opcode, Instr_Rsel, Instr_Addr} !== {1'b1, 6'h0D, 2'b00, 8'h12}) begin
      tests_failed++;
      $display("FAIL first_instr got=%h want=%h", {Instr_Valid, Instr_Opcode, Instr_Rsel, Instr_Addr},
               {1'b1, 6'h0D, 2'b00, 8'h12});
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 7; i++) begin
      if (i > 0 || 1'b1) advance();
      drive(1'b1, (i == 5), 1'b0);
      tests_run++;
      if (observe() !== expect_vec()) begin
        tests_failed++;
        $display("FAIL backpressure cyc%0d got=%h want=%h", i, observe(), expect_vec());
      end
    end
    tests_run++;
    if (Fetch_Count !== 16'd1) begin
      tests_failed++;
      $display("FAIL count_after_accept got=%h want=%h", Fetch_Count, 16'd1);
    end
    advance();
  endtask

  task automatic test_stall();
    mem[0] = 8'h5A; mem[1] = 8'h20;
    drive(1'b1, 1'b0, 1'b1); advance();
    for (int i = 0; i < 8; i++) begin
      drive((i < 2 || i > 4), 1'b1, 1'b0);
      tests_run++;
      if (observe() !== expect_vec()) begin
        tests_failed++;
        $display("FAIL stall cyc%0d got=%h want=%h", i, observe(), expect_vec());
      end
      advance();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 64) == 0);
      tests_run++;
      if (observe() !== expect_vec()) begin
        tests_failed++;
        $display("FAIL random cyc%0d got=%h want=%h", i, observe(), expect_vec());
      end
      advance();
    end
  endtask

  task automatic test_reset_mid_fetch();
    bit hit;
    hit = 1'b0;
    mem[1] = 8'h04; mem[3] = 8'h08;
    drive(1'b1, 1'b1, 1'b1); advance();
    for (int i = 0; i < 20 && !hit; i++) begin
      drive(1'b1, 1'b1, 1'b0);
      if (!in_rst && !trapped && bytes == 1 && instr_idx >= 1) begin
        Reset = 1'b1; #1;
        hit = 1'b1;
      end
      tests_run++;
      if (observe() !== expect_vec()) begin
        tests_failed++;
        $display("FAIL mid_fetch_pre cyc%0d got=%h want=%h", i, observe(), expect_vec());
      end
      advance();
    end
    tests_run++;
    if (!hit) begin
      tests_failed++;
      $display("FAIL mid_fetch_reach got=timeout want=FETCH_HI");
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      tests_run++;
      if (observe() !== expect_vec()) begin
        tests_failed++;
        $display("FAIL mid_fetch_post cyc%0d got=%h want=%h", i, observe(), expect_vec());
      end
      advance();
    end
  endtask

  task automatic test_count_wrap();
    drive(1'b1, 1'b1, 1'b0);
    force dut.fetch_count_q = 16'hFFFF;
    #1;
    release dut.fetch_count_q;
    exp_count = 16'hFFFF;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) drive(1'b1, 1'b1, 1'b0);
      tests_run++;
      if (observe() !== expect_vec()) begin
        tests_failed++;
        $display("FAIL count_wrap cyc%0d got=%h want=%h", i, observe(), expect_vec());
      end
      advance();
    end
  endtask

  task automatic test_max_opcode();
    mem[0] = 8'hA5; mem[1] = 8'hFC;
    drive(1'b1, 1'b0, 1'b1); advance();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, (i > 5), 1'b0);
      tests_run++;
      if (observe() !== expect_vec()) begin
        tests_failed++;
        $display("FAIL max_opcode cyc%0d got=%h want=%h", i, observe(), expect_vec());
      end
      advance();
    end
  endtask

  initial begin
    Reset = 1'b1; Fetch_En = 1'b0; Exec_Ready = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    test_reset_fetch();
    test_backpressure();
    test_stall();
    test_random();
    test_reset_mid_fetch();
    test_count_wrap();
    test_max_opcode();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
